itof_pipe: RTL and testbench

- Pipelined int32 to float32 converter. It is the inverse of the FPU's combinational ftoi path and implements the `itof` instruction.
- Takes a two's-complement signed 32-bit integer and produces an IEEE-754 single-precision result.
- Rounds to nearest, ties away from zero, matching the FPU's ftoi rounding convention.
- Sits in the FPU execute cluster behind a valid/ready handshake and sustains one conversion per cycle.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/lzc32.sv | 18 +
 rtl/itof_pipe.sv | 117 +++++++++++
 tb/tb_itof_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: float32 layout and the itof pipeline stage payloads.
package fpu_pkg;

  localparam int FLOAT_BIAS    = 127;
  localparam int EXP_W         = 8;
  localparam int MANT_W        = 23;
  localparam int ITOF_EXP_BASE = 158;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float32_t;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [31:0] abs;
  } itof_s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [31:0]      norm;
  } itof_s2_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; count is 31 when the input is all zeros.
module lzc32 (
  input  logic [31:0] value,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Scanning upward lets the highest set bit overwrite any lower match.
  always_comb begin
    count = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 5'(31 - i);
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/itof_pipe.sv
// Three-stage int32 -> float32 converter with valid/ready flow control.
// Rounding is ties-away-from-zero by default; define ITOF_RNE_EN for round-to-nearest-even.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid, s2_valid, s3_valid;
  logic             s1_load, s2_load, s3_load;
  logic             s1_advance;
  itof_s1_t         s1_d, s1_q;
  itof_s2_t         s2_d, s2_q;
  float32_t         s3_d;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
  logic [31:0]      s3_y;
  logic [4:0]       lz;
  logic             abs_zero;
  logic [MANT_W-1:0] mant_r;
  logic             mant_carry;
  logic             round_up;
  logic             sticky;

  // A stage may load when it is empty or its occupant leaves this cycle.
  assign s3_load    = ~s3_valid | out_ready;
  assign s2_load    = ~s2_valid | s3_load;
  assign s1_advance = s1_valid & s2_load;
  assign in_ready   = ~s1_valid | s1_advance;
  assign s1_load    = in_ready;

  always_comb begin
    s1_d.sign = in_x[31];
    s1_d.zero = (in_x == 32'd0);
    s1_d.abs  = in_x[31] ? (~in_x + 32'd1) : in_x;
  end

  lzc32 u_lzc (
    .value    (s1_q.abs),
    .count    (lz),
    .all_zero (abs_zero)
  );

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero | abs_zero;
    s2_d.norm = s1_q.abs << lz;
    s2_d.exp  = 8'(ITOF_EXP_BASE) - {3'b000, lz};
  end

  // Ties-away ignores sticky; it is folded in redundantly so the bits stay consumed.
  always_comb begin
    sticky = |s2_q.norm[6:0];
`ifdef ITOF_RNE_EN
    round_up = s2_q.norm[7] & (sticky | s2_q.norm[8]);
`else
    round_up = s2_q.norm[7] | (s2_q.norm[7] & sticky);
`endif
    {mant_carry, mant_r} = {1'b0, s2_q.norm[30:8]} + 24'(round_up);
    s3_d.sign = s2_q.sign;
    s3_d.exp  = s2_q.exp + {7'd0, mant_carry};
    s3_d.mant = mant_r;
    if (s2_q.zero | ~s2_q.norm[31]) s3_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
      if (s3_load) s3_valid <= s2_valid;
    end
  end

  // Payloads only update with a valid occupant so a stalled output holds steady.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q   <= '0;
      s1_tag <= '0;
      s2_q   <= '0;
      s2_tag <= '0;
      s3_y   <= '0;
      s3_tag <= '0;
    end else begin
      if (s1_load && in_valid) begin
        s1_q   <= s1_d;
        s1_tag <= in_tag;
      end
      if (s2_load && s1_valid) begin
        s2_q   <= s2_d;
        s2_tag <= s1_tag;
      end
      if (s3_load && s2_valid) begin
        s3_y   <= s3_d;
        s3_tag <= s2_tag;
      end
    end
  end

  assign out_valid = s3_valid;
  assign out_y     = s3_y;
  assign out_tag   = s3_tag;

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed values, mid-stream reset, backpressure and throughput.
module tb_itof_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               passes = 0;
  int               cyc = 0;
  int               accepted = 0;
  int               retired = 0;
  int               first_ret = -1;
  int               last_ret = -1;
  bit               check_lat = 1'b0;
  bit               held = 1'b0;
  logic [31:0]      held_y;
  logic [TAG_W-1:0] held_tag;
  logic [31:0]      dx[9];
  logic [31:0]      dy[9];
  logic [31:0]      bx[8];

  itof_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  // Reference: locate the MSB arithmetically, then round the discarded remainder.
  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    longint v, mag, q, rem, half;
    int     e, sh;
    logic   s;
    v   = longint'($signed(x));
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) return 32'h0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'sd1 << (sh - 1);
`ifdef ITOF_RNE_EN
      if (rem > half || (rem == half && q[0])) q++;
`else
      if (rem >= half) q++;
`endif
      if (q == (64'sd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(127 + e), q[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("[TB] FAIL %s: got %h expected %h", name, obs, expv);
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance past the rising edge.
  task automatic step(input bit v, input logic [31:0] x, input logic [TAG_W-1:0] t,
                      input logic [31:0] ey, input bit ordy, output bit acc);
    exp_t e;
    int   inflight;
    in_valid  = v;
    in_x      = x;
    in_tag    = t;
    out_ready = ordy;
    @(negedge clk);
    inflight = accepted - retired;
    check("in_ready", {31'd0, in_ready}, {31'd0, (inflight < 3) || ordy});
    if (held && out_valid) begin
      check("stall_y", out_y, held_y);
      check("stall_tag", {28'd0, out_tag}, {28'd0, held_tag});
    end
    if (out_valid && out_ready) begin
      check("result_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_y", out_y, e.y);
        check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
        if (check_lat) check("latency", cyc - e.cyc, 3);
      end
      retired++;
      if (first_ret < 0) first_ret = cyc;
      last_ret = cyc;
    end
    held     = out_valid && !out_ready;
    held_y   = out_y;
    held_tag = out_tag;
    acc = v && in_ready;
    if (acc) begin
      e.y   = ey;
      e.tag = t;
      e.cyc = cyc;
      exp_q.push_back(e);
      accepted++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] x;
    bit          ordy;

    dx = '{32'h1, 32'hFFFFFFFF, 32'h3, 32'h0, 32'h7FFFFFFF, 32'h80000000,
           32'h00FFFFFF, 32'h01000001, 32'h01000003};
    dy = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'h00000000, 32'h4F000000,
           32'hCF000000, 32'h4B7FFFFF, 32'h4B800001, 32'h4B800002};
`ifdef ITOF_RNE_EN
    dy[7] = 32'h4B800000;
`endif

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_y", out_y, 32'd0);
    check("reset_out_tag", {28'd0, out_tag}, 32'd0);
    rstn = 1'b1;
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] directed values");
    check_lat = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, dx[i], 4'(i), dy[i], 1'b1, acc);
      check("directed_accept", {31'd0, acc}, 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, acc);
    check("directed_drained", exp_q.size(), 0);
    check_lat = 1'b0;

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      step(1'b1, x, 4'(i + 3), ref_itof(x), 1'b1, acc);
    end
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out_y", out_y, 32'd0);
    exp_q.delete();
    accepted = 0;
    retired  = 0;
    held     = 1'b0;
    rstn     = 1'b1;
    #1;
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, acc);
    check("midreset_no_stale", retired, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) bx[i] = $urandom;
    idx = 0;
    for (int it = 0; it < 80 && (idx < 8 || exp_q.size() > 0); it++) begin
      ordy = (it >= 3 && it < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      if (idx < 8) step(1'b1, bx[idx], 4'(8 + idx), ref_itof(bx[idx]), ordy, acc);
      else         step(1'b0, '0, '0, '0, ordy, acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 8);
    check("bp_all_retired", exp_q.size(), 0);

    $display("[TB] throughput");
    first_ret = -1;
    last_ret  = -1;
    for (int i = 0; i < 100; i++) begin
      case (i % 4)
        0:       x = 32'($urandom_range(0, 32'h01000000));
        1:       x = -32'($urandom_range(0, 32'h01000000));
        default: x = $urandom;
      endcase
      step(1'b1, x, 4'(i), ref_itof(x), 1'b1, acc);
      check("tp_accept", {31'd0, acc}, 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, acc);
    check("tp_drained", exp_q.size(), 0);
    check("tp_window", {31'd0, (first_ret >= 0) && (last_ret - first_ret <= 101)}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
